// File: rtl/spi_flash_read_ctrl_if.sv
// Requester and SPI-master signal bundle for spi_flash_read_ctrl.
// The controller uses the slave view; the requester/SPI side uses master.
interface spi_flash_read_ctrl_if #(
    parameter int MAX_READ_BYTES   = 4,
    parameter int MAX_BYTES_PER_CS = MAX_READ_BYTES + 4,
    parameter int LEN_W            = $clog2(MAX_READ_BYTES + 1),
    parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
);
    logic             i_Req;
    logic [23:0]      i_Addr;
    logic [LEN_W-1:0] i_Len;
    logic             o_Busy;
    logic [7:0]       o_Data;
    logic             o_Data_Valid;
    logic [LEN_W-1:0] o_Data_Idx;
    logic             o_Done;
    logic             o_Err;
    logic [CNT_W-1:0] o_TX_Count;
    logic [7:0]       o_TX_Byte;
    logic             o_TX_DV;
    logic             i_TX_Ready;
    logic             i_RX_DV;
    logic [7:0]       i_RX_Byte;

    modport slave (
        input  i_Req, i_Addr, i_Len, i_TX_Ready, i_RX_DV, i_RX_Byte,
        output o_Busy, o_Data, o_Data_Valid, o_Data_Idx, o_Done, o_Err,
               o_TX_Count, o_TX_Byte, o_TX_DV
    );

    modport master (
        output i_Req, i_Addr, i_Len, i_TX_Ready, i_RX_DV, i_RX_Byte,
        input  o_Busy, o_Data, o_Data_Valid, o_Data_Idx, o_Done, o_Err,
               o_TX_Count, o_TX_Byte, o_TX_DV
    );
endinterface

// File: rtl/spi_flash_read_ctrl.sv
// Serial-flash READ (0x03) sequencer driving a single-CS SPI master:
// opcode + 24-bit address + dummy bytes out, data-phase RX bytes forwarded with index.
module spi_flash_read_ctrl #(
    parameter int MAX_READ_BYTES   = 4,
    parameter int MAX_BYTES_PER_CS = MAX_READ_BYTES + 4,
    parameter int LEN_W            = $clog2(MAX_READ_BYTES + 1),
    parameter int CNT_W            = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    spi_flash_read_ctrl_if.slave  bus
);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_READ_BYTES);
    localparam logic [CNT_W-1:0] CMD_BYTES = CNT_W'(4);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, SEND, GUARD, WAIT_RDY, FINISH} state_t;

    state_t           r_State;
    logic [23:0]      r_Addr;
    logic [CNT_W-1:0] r_Tx_Cnt;
    logic [CNT_W-1:0] r_Rx_Cnt;
    logic [CNT_W-1:0] r_TX_Count;
    logic [7:0]       r_TX_Byte;
    logic             r_TX_DV;
    logic             r_Busy;
    logic [7:0]       r_Data;
    logic             r_Data_Valid;
    logic [LEN_W-1:0] r_Data_Idx;
    logic             r_Done;
    logic             r_Err;

    logic             w_Len_Ok;
    logic [7:0]       w_Tx_Sel;
    logic [CNT_W-1:0] w_Data_Idx;

    assign w_Len_Ok   = (bus.i_Len != '0) && (bus.i_Len <= MAX_LEN);
    assign w_Data_Idx = r_Rx_Cnt - CMD_BYTES;

    always_comb begin
        w_Tx_Sel = 8'h00;
        case (r_Tx_Cnt)
            CNT_W'(0): w_Tx_Sel = 8'h03;
            CNT_W'(1): w_Tx_Sel = r_Addr[23:16];
            CNT_W'(2): w_Tx_Sel = r_Addr[15:8];
            CNT_W'(3): w_Tx_Sel = r_Addr[7:0];
            default:   w_Tx_Sel = 8'h00;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= IDLE;
            r_Addr       <= '0;
            r_Tx_Cnt     <= '0;
            r_Rx_Cnt     <= '0;
            r_TX_Count   <= '0;
            r_TX_Byte    <= '0;
            r_TX_DV      <= 1'b0;
            r_Busy       <= 1'b0;
            r_Data       <= '0;
            r_Data_Valid <= 1'b0;
            r_Data_Idx   <= '0;
            r_Done       <= 1'b0;
            r_Err        <= 1'b0;
        end else begin
            r_TX_DV      <= 1'b0;
            r_Done       <= 1'b0;
            r_Err        <= 1'b0;
            r_Data_Valid <= 1'b0;

            // First four RX bytes echo the command phase and are dropped.
            if (r_State != IDLE && bus.i_RX_DV) begin
                r_Rx_Cnt <= r_Rx_Cnt + ONE;
                if (r_Rx_Cnt >= CMD_BYTES) begin
                    r_Data       <= bus.i_RX_Byte;
                    r_Data_Idx   <= w_Data_Idx[LEN_W-1:0];
                    r_Data_Valid <= 1'b1;
                end
            end

            case (r_State)
                IDLE: begin
                    r_Busy <= 1'b0;
                    if (bus.i_Req) begin
                        r_Busy <= 1'b1;
                        if (!w_Len_Ok) begin
                            r_Err <= 1'b1;
                        end else begin
                            r_Addr     <= bus.i_Addr;
                            r_TX_Count <= CNT_W'(bus.i_Len) + CMD_BYTES;
                            r_Tx_Cnt   <= '0;
                            r_Rx_Cnt   <= '0;
                            r_State    <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (bus.i_TX_Ready) begin
                        r_TX_DV   <= 1'b1;
                        r_TX_Byte <= w_Tx_Sel;
                        r_Tx_Cnt  <= r_Tx_Cnt + ONE;
                        r_State   <= GUARD;
                    end
                end
                // Ready is still stale-high here; the master only drops it after seeing DV.
                GUARD: r_State <= WAIT_RDY;
                WAIT_RDY: begin
                    if (bus.i_TX_Ready)
                        r_State <= (r_Tx_Cnt < r_TX_Count) ? SEND : FINISH;
                end
                FINISH: begin
                    if (r_Rx_Cnt == r_TX_Count && bus.i_TX_Ready) begin
                        r_Done  <= 1'b1;
                        r_State <= IDLE;
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end

    assign bus.o_Busy       = r_Busy;
    assign bus.o_Data       = r_Data;
    assign bus.o_Data_Valid = r_Data_Valid;
    assign bus.o_Data_Idx   = r_Data_Idx;
    assign bus.o_Done       = r_Done;
    assign bus.o_Err        = r_Err;
    assign bus.o_TX_Count   = r_TX_Count;
    assign bus.o_TX_Byte    = r_TX_Byte;
    assign bus.o_TX_DV      = r_TX_DV;
endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: SPI master + flash behavioural model with random
// byte latency and CS gap, directed and random reads checked against flash contents.
module tb_spi_flash_read_ctrl;
    localparam int MRB   = 4;
    localparam int LEN_W = $clog2(MRB + 1);
    localparam int TMO   = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_flash_read_ctrl_if #(.MAX_READ_BYTES(MRB)) bus ();

    spi_flash_read_ctrl #(.MAX_READ_BYTES(MRB)) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (bus)
    );

    // Flash contents: explicit overrides, otherwise a fixed function of address.
    logic [7:0] mem [logic [23:0]];
    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h96;
    endfunction

    // SPI master + flash model
    logic        s_rst, s_dv;
    logic [7:0]  s_b, resp;
    logic [23:0] fa;
    int          s_cnt, cs_cnt, nb, bsy, gap;
    initial begin
        bus.i_TX_Ready = 1'b1;
        bus.i_RX_DV    = 1'b0;
        bus.i_RX_Byte  = 8'h00;
        nb = 0; bsy = 0; gap = 0; cs_cnt = 0; fa = '0; resp = '0;
        forever begin
            @(negedge clk);
            s_dv  = bus.o_TX_DV;
            s_b   = bus.o_TX_Byte;
            s_cnt = int'(bus.o_TX_Count);
            @(posedge clk);
            s_rst = rst;
            #1;
            bus.i_RX_DV = 1'b0;
            if (s_rst) begin
                bus.i_TX_Ready = 1'b1;
                nb = 0; bsy = 0; gap = 0;
            end else if (bsy > 0) begin
                bsy--;
                if (bsy == 0) begin
                    bus.i_RX_DV   = 1'b1;
                    bus.i_RX_Byte = resp;
                    nb++;
                    if (nb == cs_cnt) begin
                        nb  = 0;
                        gap = $urandom_range(1, 3);
                    end else begin
                        bus.i_TX_Ready = 1'b1;
                    end
                end
            end else if (gap > 0) begin
                gap--;
                if (gap == 0) bus.i_TX_Ready = 1'b1;
            end else if (s_dv) begin
                if (nb == 0) cs_cnt = s_cnt;
                bus.i_TX_Ready = 1'b0;
                bsy = $urandom_range(1, 4);
                case (nb)
                    1: fa[23:16] = s_b;
                    2: fa[15:8]  = s_b;
                    3: fa[7:0]   = s_b;
                    default: ;
                endcase
                resp = (nb < 4) ? 8'($urandom) : mem_rd(fa + 24'(nb - 4));
            end
        end
    end

    // Observation state, owned by the main process
    int         n_cmp = 0, n_bad = 0;
    int         cyc = 0, n_done = 0, n_err = 0, hs_viol = 0;
    int         done_cyc = 0, last_dv = 0;
    logic       prev_dv = 1'b0, done_busy = 1'b0;
    logic [7:0] txq [$];
    logic [7:0] dq [$];
    int         cntq [$];
    int         iq [$];
    int         tx_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.o_TX_DV) begin
            if (!bus.i_TX_Ready || prev_dv) hs_viol++;
            txq.push_back(bus.o_TX_Byte);
            cntq.push_back(int'(bus.o_TX_Count));
            tx_cyc.push_back(cyc);
        end
        prev_dv = bus.o_TX_DV;
        if (bus.o_Data_Valid) begin
            dq.push_back(bus.o_Data);
            iq.push_back(int'(bus.o_Data_Idx));
            last_dv = cyc;
        end
        if (bus.o_Done) begin
            n_done++;
            done_cyc  = cyc;
            done_busy = bus.o_Busy;
            if (bus.o_Err) hs_viol++;
        end
        if (bus.o_Err) n_err++;
    endtask

    task automatic clear_obs();
        txq.delete(); dq.delete(); cntq.delete(); iq.delete(); tx_cyc.delete();
        n_done = 0; n_err = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  bus.o_Busy, 0);
        chk({tag, "_dval"},  bus.o_Data_Valid, 0);
        chk({tag, "_done"},  bus.o_Done, 0);
        chk({tag, "_err"},   bus.o_Err, 0);
        chk({tag, "_txdv"},  bus.o_TX_DV, 0);
        chk({tag, "_data"},  bus.o_Data, 0);
        chk({tag, "_idx"},   bus.o_Data_Idx, 0);
        chk({tag, "_txb"},   bus.o_TX_Byte, 0);
        chk({tag, "_txcnt"}, bus.o_TX_Count, 0);
    endtask

    task automatic check_seg(input string tag, input logic [23:0] a, input int len,
                             input int toff, input int doff);
        logic [7:0] hdr [4];
        logic [7:0] e;
        hdr[0] = 8'h03; hdr[1] = a[23:16]; hdr[2] = a[15:8]; hdr[3] = a[7:0];
        for (int i = 0; i < len + 4; i++) begin
            if (toff + i < txq.size()) begin
                e = (i < 4) ? hdr[i] : 8'h00;
                chk({tag, "_txbyte"}, txq[toff + i], e);
                chk({tag, "_txcount"}, cntq[toff + i], len + 4);
            end
        end
        for (int i = 0; i < len; i++) begin
            if (doff + i < dq.size()) begin
                chk({tag, "_data"}, dq[doff + i], mem_rd(a + 24'(i)));
                chk({tag, "_idx"}, iq[doff + i], i);
            end
        end
    endtask

    // One read; intr_at >= 0 pulses a stray request (addr 0) that many cycles in.
    task automatic do_read(input string tag, input logic [23:0] a, input int len, input int intr_at);
        int k;
        clear_obs();
        bus.i_Addr = a;
        bus.i_Len  = LEN_W'(len);
        bus.i_Req  = 1'b1;
        step();
        chk({tag, "_busy_acc"}, bus.o_Busy, 1);
        bus.i_Req = 1'b0;
        k = 0;
        while (n_done == 0 && k < TMO) begin
            if (k == intr_at) begin
                bus.i_Addr = 24'h000000;
                bus.i_Req  = 1'b1;
            end else begin
                bus.i_Req = 1'b0;
            end
            step();
            k++;
        end
        bus.i_Req = 1'b0;
        chk({tag, "_no_timeout"}, k < TMO, 1);
        chk({tag, "_busy_at_done"}, done_busy, 1);
        step(); step();
        chk({tag, "_busy_fell"}, bus.o_Busy, 0);
        chk({tag, "_ndone"}, n_done, 1);
        chk({tag, "_nerr"}, n_err, 0);
        chk({tag, "_ntx"}, txq.size(), len + 4);
        chk({tag, "_ndata"}, dq.size(), len);
        chk({tag, "_done_after_data"}, done_cyc > last_dv, 1);
        chk({tag, "_handshake"}, hs_viol, 0);
        check_seg(tag, a, len, 0, 0);
    endtask

    task automatic do_err(input string tag, input int len);
        clear_obs();
        bus.i_Addr = 24'h555555;
        bus.i_Len  = LEN_W'(len);
        bus.i_Req  = 1'b1;
        step();
        chk({tag, "_err_pulse"}, bus.o_Err, 1);
        chk({tag, "_busy_pulse"}, bus.o_Busy, 1);
        bus.i_Req = 1'b0;
        repeat (6) step();
        chk({tag, "_nerr"}, n_err, 1);
        chk({tag, "_ntx"}, txq.size(), 0);
        chk({tag, "_ndone"}, n_done, 0);
        chk({tag, "_busy_low"}, bus.o_Busy, 0);
    endtask

    initial begin
        int          k, d1_cyc, d1_tx;
        logic [23:0] a1, a2;
        bus.i_Req = 1'b0; bus.i_Addr = '0; bus.i_Len = '0;
        rst = 1'b1;
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // Basic read
        mem[24'hADBEEF] = 8'h5A;
        mem[24'hADBEF0] = 8'hC3;
        do_read("basic", 24'hADBEEF, 2, -1);
        if (dq.size() >= 2) begin
            chk("basic_byte0", dq[0], 8'h5A);
            chk("basic_byte1", dq[1], 8'hC3);
        end

        // Length limits
        do_err("len0", 0);
        do_err("len_over", MRB + 1);
        do_read("len_max", 24'($urandom), MRB, -1);

        // Stray request while busy
        do_read("busy_req", 24'h123456, 3, 6);

        // Back-to-back with request held high
        clear_obs();
        a1 = 24'h2468AC; a2 = 24'h13579B;
        bus.i_Addr = a1; bus.i_Len = LEN_W'(2); bus.i_Req = 1'b1;
        k = 0;
        while (n_done < 1 && k < TMO) begin step(); k++; end
        bus.i_Addr = a2; bus.i_Len = LEN_W'(1);
        d1_cyc = done_cyc; d1_tx = txq.size();
        k = 0;
        while (n_done < 2 && k < TMO) begin step(); k++; end
        bus.i_Req = 1'b0;
        step(); step();
        chk("b2b_ndone", n_done, 2);
        chk("b2b_tx_first", d1_tx, 6);
        chk("b2b_ntx", txq.size(), 11);
        if (tx_cyc.size() > 6) chk("b2b_start_after_done", tx_cyc[6] > d1_cyc, 1);
        chk("b2b_busy_fell", bus.o_Busy, 0);
        check_seg("b2b_1", a1, 2, 0, 0);
        check_seg("b2b_2", a2, 1, 6, 2);

        // Reset mid-transfer
        clear_obs();
        bus.i_Addr = 24'hC0FFEE; bus.i_Len = LEN_W'(MRB); bus.i_Req = 1'b1;
        step();
        bus.i_Req = 1'b0;
        k = 0;
        while (txq.size() < 2 && k < TMO) begin step(); k++; end
        chk("midrst_reached", txq.size(), 2);
        rst = 1'b1;
        step();
        chk_zero("midrst");
        rst = 1'b0;
        repeat (20) step();
        chk("midrst_no_done", n_done, 0);
        chk("midrst_no_tx", txq.size(), 2);
        do_read("after_rst", 24'h000010, 1, -1);

        // Random reads
        for (int n = 0; n < 10; n++) begin
            do_read("rand", 24'($urandom), $urandom_range(1, MRB),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : -1);
        end

        chk("handshake_final", hs_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
